// File: rtl/replay_buffer.sv
// replay_buffer: instant-replay recorder/player.
// Records one position snapshot per frame into a circular buffer and, when a
// point is scored, plays the buffered frames back in slow motion.
module replay_buffer #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int POS_W  = 10,
    parameter int SLOW   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             rec_en,
    input  logic             point_scored,
    input  logic             skip,
    input  logic [POS_W-1:0] in_ball_x,
    input  logic [POS_W-1:0] in_ball_y,
    input  logic [POS_W-1:0] in_p1_x,
    input  logic [POS_W-1:0] in_p1_y,
    input  logic [POS_W-1:0] in_p2_x,
    input  logic [POS_W-1:0] in_p2_y,
    output logic [POS_W-1:0] out_ball_x,
    output logic [POS_W-1:0] out_ball_y,
    output logic [POS_W-1:0] out_p1_x,
    output logic [POS_W-1:0] out_p1_y,
    output logic [POS_W-1:0] out_p2_x,
    output logic [POS_W-1:0] out_p2_y,
    output logic             replaying,
    output logic             replay_done
);

    localparam int SC_W   = (SLOW > 1) ? $clog2(SLOW) : 1;
    localparam int SNAP_W = 6 * POS_W;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(SLOW - 1);
    localparam logic [SC_W-1:0]   SC_ONE   = SC_W'(1);

    typedef enum logic {REC, PLAY} state_t;

    state_t state, state_nxt;

    logic [SNAP_W-1:0] mem [DEPTH];
    logic [SNAP_W-1:0] rd_data;
    logic [SNAP_W-1:0] in_snap;

    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, new_wr_ptr;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [ADDR_W:0]   count, count_nxt, new_count;
    logic [ADDR_W:0]   remaining, remaining_nxt;
    logic [SC_W-1:0]   slow_cnt, slow_cnt_nxt;
    logic              skip_req, skip_req_nxt;
    logic              replay_done_nxt;
    logic              mem_we;

    assign in_snap   = {in_ball_x, in_ball_y, in_p1_x, in_p1_y, in_p2_x, in_p2_y};
    assign replaying = (state == PLAY);

    // State and control register update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= REC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            remaining   <= '0;
            slow_cnt    <= '0;
            skip_req    <= 1'b0;
            replay_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            remaining   <= remaining_nxt;
            slow_cnt    <= slow_cnt_nxt;
            skip_req    <= skip_req_nxt;
            replay_done <= replay_done_nxt;
        end
    end

    // Next-state logic: recording, replay entry, slow-motion stepping and exit.
    always_comb begin
        state_nxt       = state;
        wr_ptr_nxt      = wr_ptr;
        rd_ptr_nxt      = rd_ptr;
        count_nxt       = count;
        remaining_nxt   = remaining;
        slow_cnt_nxt    = slow_cnt;
        skip_req_nxt    = skip_req;
        replay_done_nxt = 1'b0;
        mem_we          = 1'b0;
        new_wr_ptr      = wr_ptr + PTR_ONE;
        new_count       = (count == CNT_FULL) ? count : count + CNT_ONE;

        case (state)
            REC: begin
                if (frame_tick && rec_en) begin
                    mem_we     = 1'b1;
                    wr_ptr_nxt = new_wr_ptr;
                    count_nxt  = new_count;
                    if (point_scored) begin
                        // A full count wraps to zero in the low bits, so the
                        // oldest slot is simply the next write slot.
                        rd_ptr_nxt    = new_wr_ptr - new_count[ADDR_W-1:0];
                        remaining_nxt = new_count;
                        slow_cnt_nxt  = '0;
                        state_nxt     = PLAY;
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (skip_req || (slow_cnt == SC_LAST && remaining == CNT_ONE)) begin
                        state_nxt       = REC;
                        count_nxt       = '0;
                        skip_req_nxt    = 1'b0;
                        replay_done_nxt = 1'b1;
                    end else begin
                        // A skip arriving on this tick applies to the next one.
                        skip_req_nxt = skip;
                        if (slow_cnt == SC_LAST) begin
                            rd_ptr_nxt    = rd_ptr + PTR_ONE;
                            remaining_nxt = remaining - CNT_ONE;
                            slow_cnt_nxt  = '0;
                        end else begin
                            slow_cnt_nxt = slow_cnt + SC_ONE;
                        end
                    end
                end else begin
                    skip_req_nxt = skip_req | skip;
                end
            end
            default: state_nxt = REC;
        endcase
    end

    // Snapshot memory write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= in_snap;
        end
    end

    // Snapshot memory synchronous read port.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_ptr];
    end

    // Renderer outputs: live positions while recording, buffered ones in replay.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {out_ball_x, out_ball_y, out_p1_x, out_p1_y, out_p2_x, out_p2_y} <= '0;
        end else if (state == PLAY) begin
            {out_ball_x, out_ball_y, out_p1_x, out_p1_y, out_p2_x, out_p2_y} <= rd_data;
        end else begin
            {out_ball_x, out_ball_y, out_p1_x, out_p1_y, out_p2_x, out_p2_y} <= in_snap;
        end
    end

endmodule
